// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: bubble word, reset vector and fetch FSM states.
package cpu_pkg;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/fetch_buffer.sv
// One-entry skid buffer holding a fetched instruction and its PC+4 for decode.
module fetch_buffer import cpu_pkg::*; #(
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        consume,
    input  logic        flush,
    input  logic [31:0] load_data,
    input  logic [31:0] load_pc,
    output logic [31:0] data,
    output logic [31:0] pc,
    output logic        valid
);

    // Flush beats refill, refill beats consume, so a same-edge refill keeps the entry valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= NOP_INSTR;
            pc    <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single outstanding imem request, one-entry buffer feeding the FD register.
module fetch_unit import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic                fd_load_enable,
    output logic [31:0]         fd_pc_value_next,
    output logic [31:0]         fd_instruction
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc, fetch_addr;
    logic         buf_valid;
    logic [31:0]  buf_data, buf_pc;
    logic         consume, accept, load;

    assign consume = buf_valid && !stall;

    // Only request when the response will have somewhere to land; masked in reset.
    assign imem.imem_req  = rst && (state == FETCH) && (!buf_valid || consume);
    assign imem.imem_addr = pc;
    assign accept         = imem.imem_req && imem.imem_ready;
    assign load           = (state == WAIT) && imem.imem_rvalid && !redirect_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (accept) state_nxt = redirect_valid ? DRAIN : WAIT;
            WAIT:    if (imem.imem_rvalid) state_nxt = FETCH;
                     else if (redirect_valid) state_nxt = DRAIN;
            DRAIN:   if (imem.imem_rvalid) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (accept) fetch_addr <= pc;
            if (redirect_valid) pc <= redirect_pc & 32'hFFFF_FFFC;
            else if (accept)    pc <= pc + 32'd4;
        end
    end

    fetch_buffer #(.NOP_INSTR(NOP_INSTR)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .consume   (consume),
        .flush     (redirect_valid),
        .load_data (imem.imem_rdata),
        .load_pc   (fetch_addr + 32'd4),
        .data      (buf_data),
        .pc        (buf_pc),
        .valid     (buf_valid)
    );

    assign fd_load_enable   = !stall;
    assign fd_instruction   = buf_valid ? buf_data : NOP_INSTR;
    assign fd_pc_value_next = buf_valid ? buf_pc   : 32'h0;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, bubble word sent to decode.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 stall  in  1  decode stalled; FD register must hold.
REQ-006 redirect_valid  in  1  branch/jump taken this cycle.
REQ-007 redirect_pc  in  32  target address; bits [1:0] ignored and forced to 0.
REQ-008 imem_req  out  1  fetch request valid.
REQ-009 imem_addr  out  32  word-aligned fetch address.
REQ-010 imem_ready  in  1  memory accepts request this cycle.
REQ-011 imem_rvalid  in  1  response valid; earliest one cycle after acceptance.
REQ-012 imem_rdata  in  32  fetched instruction word.
REQ-013 fd_load_enable  out  1  load strobe to the FD pipeline register.
REQ-014 fd_pc_value_next  out  32  PC+4 of the delivered instruction (0 for bubble).
REQ-015 fd_instruction  out  32  delivered instruction, or NOP_INSTR.

Function
REQ-016 The unit SHALL keep at most one memory request outstanding.
REQ-017 The FSM SHALL have states FETCH (imem_req=1), WAIT (request accepted, awaiting rvalid), DRAIN (awaiting a squashed response).
REQ-018 FETCH->WAIT on imem_req&&imem_ready; address used = pc; pc advances to pc+4 on acceptance, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 imem_req SHALL be asserted in FETCH only when the one-entry buffer is empty or is being consumed in the same cycle; otherwise the FSM stays in FETCH with imem_req=0.
REQ-020 WAIT->FETCH on imem_rvalid: buffer captures {rdata, fetch_addr+4}, buf_valid=1.
REQ-021 fd_load_enable SHALL equal !stall, combinationally.
REQ-022 fd outputs SHALL be driven from the buffer when buf_valid=1, otherwise NOP_INSTR and 0.
REQ-023 Buffer consumed (buf_valid cleared) on any cycle with buf_valid=1 and stall=0, unless refilled that same edge.
REQ-024 Latency: request accepted in cycle N, rvalid in N+1 -> buffer valid in N+2 -> FD register loads at end of N+2.
REQ-025 Redirect has highest priority: pc<=redirect_pc, buf_valid<=0, regardless of stall.
REQ-026 Redirect in WAIT without rvalid, or in FETCH with a request accepted that cycle -> DRAIN.
REQ-027 Redirect in WAIT coincident with rvalid: response dropped, next state FETCH.
REQ-028 Redirect in DRAIN: pc updated, state remains DRAIN.
REQ-029 DRAIN->FETCH on imem_rvalid; data discarded, buffer unchanged.
REQ-030 While stall=1 and no redirect, buffer contents and fd outputs SHALL be held stable.

Reset
REQ-031 On rst low, asynchronously: state=FETCH, pc=RESET_PC, buf_valid=0, buffer data=NOP_INSTR/0.
REQ-032 During reset, imem_req=0, fd_instruction=NOP_INSTR, fd_pc_value_next=0.
REQ-033 A reset asserted mid-WAIT abandons the request; the first response after reset release is expected only for a new request.

Structure
REQ-034 Shared package cpu_pkg SHALL hold NOP constant, RESET_PC default and the fetch state enum.
REQ-035 The one-entry buffer SHALL be a sub-module fetch_buffer (load, consume, flush, data/pc/valid).

Verification
REQ-036 Reset release, imem_ready=1, rvalid one cycle after each accept, rdata=addr^32'hA5A5_0000 -> fd_instruction sequence for addresses 0,4,8, fd_pc_value_next 4,8,12, and a bubble cycle between instructions (REQ-019/024 timing).
REQ-037 Stall for 3 cycles with buffer holding 32'h1234_5678 -> fd_load_enable=0, outputs stable, no new imem_req; then stall=0 -> value consumed once.
REQ-038 redirect to 32'h0000_0103 while in WAIT -> next accepted imem_addr=32'h0000_0100; squashed rdata never reaches fd_instruction.
REQ-039 redirect coincident with rvalid -> response dropped, FETCH next cycle with new pc.
REQ-040 pc=32'hFFFF_FFFC accepted -> fd_pc_value_next=0, next imem_addr=0.
REQ-041 rst low during WAIT, then released -> imem_addr=RESET_PC, buf_valid=0, stray rvalid in DRAIN-free FETCH ignored.
